// File: rtl/mul_add_checker_8bit_if.sv
// mul_add_checker_8bit_if: request/operand/result bundle between the ALU and the MAC checker
interface mul_add_checker_8bit_if;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic [7:0]  addend;
  logic [7:0]  expected;
  logic [15:0] product;
  logic        match;
  logic        busy;
  logic        done;
  modport master (
    output start, multiplicand, multiplier, addend, expected,
    input  product, match, busy, done
  );
  modport slave (
    input  start, multiplicand, multiplier, addend, expected,
    output product, match, busy, done
  );
endinterface

// File: rtl/mul_add_checker_8bit.sv
// mul_add_checker_8bit: shift-add A*B+addend, also verifies a divider result against its dividend
module mul_add_checker_8bit (
  input  logic                 clk,
  input  logic                 reset,
  mul_add_checker_8bit_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MULTIPLYING = 2'd1;
  localparam logic [1:0] FINISHED = 2'd2;
  logic [1:0]  r_state;
  logic [16:0] r_acc;
  logic [7:0]  r_a;
  logic [7:0]  r_exp;
  logic [3:0]  r_count;
  logic        r_rem_ok;
  logic [15:0] r_product;
  logic        r_match;
  logic        r_done;
  logic [8:0]  w_sum;
  // one multiply step: add A into the high half when the current multiplier bit is set
  always_comb w_sum = {1'b0, r_acc[15:8]} + (r_acc[0] ? {1'b0, r_a} : 9'd0);
  // sequencer: load operands in IDLE, eight shift-add steps, then publish result for one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_a       <= '0;
      r_exp     <= '0;
      r_count   <= '0;
      r_rem_ok  <= 1'b0;
      r_product <= '0;
      r_match   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_a      <= bus.multiplicand;
          r_exp    <= bus.expected;
          r_acc    <= {1'b0, bus.addend, bus.multiplier};
          r_count  <= 4'd8;
          r_rem_ok <= bus.addend < bus.multiplier;
          r_state  <= MULTIPLYING;
        end
        MULTIPLYING: begin
          r_acc   <= {1'b0, w_sum, r_acc[7:1]};
          r_count <= r_count - 4'd1;
          if (r_count == 4'd1) r_state <= FINISHED;
        end
        FINISHED: begin
          r_product <= r_acc[15:0];
          r_match   <= (r_acc == {9'd0, r_exp}) & r_rem_ok;
          r_done    <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.product = r_product;
  assign bus.match   = r_match;
  assign bus.done    = r_done;
  assign bus.busy    = r_state != IDLE;
endmodule

// File: tb/tb_mul_add_checker_8bit.sv
// tb_mul_add_checker_8bit: randomized and directed checks of the MAC checker against an arithmetic model
module tb_mul_add_checker_8bit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  mul_add_checker_8bit_if bus();
  mul_add_checker_8bit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [15:0] model_product(input int a, input int b, input int ad);
    return 16'(a * b + ad);
  endfunction

  function automatic logic model_match(input int a, input int b, input int ad, input int ex);
    return (a * b + ad == ex) && (ad < b);
  endfunction

  // call at a negedge; returns after done is seen (lat = edges after start sample, 0 on timeout)
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ad, input logic [7:0] ex,
                        output int lat, output logic hold_ok, output logic busy_ok);
    logic [15:0] p0;
    bus.multiplicand = a;
    bus.multiplier = b;
    bus.addend = ad;
    bus.expected = ex;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    p0 = bus.product;
    hold_ok = 1'b1;
    busy_ok = bus.busy;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = n;
        busy_ok &= !bus.busy;
        break;
      end
      busy_ok &= bus.busy;
      hold_ok &= (bus.product == p0);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.multiplicand = 8'd0;
    bus.multiplier = 8'd0;
    bus.addend = 8'd0;
    bus.expected = 8'd0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.product, bus.match, bus.busy, bus.done} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_state: product=%h match=%b busy=%b done=%b, required all 0", bus.product, bus.match, bus.busy, bus.done);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.product, bus.match, bus.busy, bus.done} !== 19'd0) begin
      n_fail++;
      $display("FAIL idle_no_start: product=%h match=%b busy=%b done=%b, required all 0", bus.product, bus.match, bus.busy, bus.done);
    end
  endtask

  task automatic test_directed();
    logic [7:0] tv [5][4];
    int lat;
    logic hold_ok, busy_ok;
    tv = '{'{8'd13, 8'd19, 8'd5, 8'd252}, '{8'd13, 8'd19, 8'd5, 8'd251}, '{8'd12, 8'd19, 8'd24, 8'd252},
           '{8'd255, 8'd255, 8'd255, 8'd0}, '{8'd0, 8'd0, 8'd7, 8'd7}};
    for (int i = 0; i < 5; i++) begin
      run_op(tv[i][0], tv[i][1], tv[i][2], tv[i][3], lat, hold_ok, busy_ok);
      n_checks++;
      if (lat != 9 || !busy_ok) begin
        n_fail++;
        $display("FAIL dir%0d_timing: latency=%0d busy_ok=%b, required 9 and 1", i, lat, busy_ok);
      end
      n_checks++;
      if (bus.product !== model_product(tv[i][0], tv[i][1], tv[i][2]) || bus.match !== model_match(tv[i][0], tv[i][1], tv[i][2], tv[i][3])) begin
        n_fail++;
        $display("FAIL dir%0d_result: product=%h match=%b, required %h %b", i, bus.product, bus.match,
                 model_product(tv[i][0], tv[i][1], tv[i][2]), model_match(tv[i][0], tv[i][1], tv[i][2], tv[i][3]));
      end
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL dir%0d_done_pulse: done=%b one cycle later, required 0", i, bus.done);
      end
    end
  endtask

  task automatic test_start_while_busy();
    bool_done: begin end
    bus.multiplicand = 8'd13;
    bus.multiplier = 8'd19;
    bus.addend = 8'd5;
    bus.expected = 8'd252;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.multiplicand = 8'd99;
    bus.multiplier = 8'd7;
    bus.addend = 8'd1;
    bus.expected = 8'd0;
    bus.start = 1'b1;
    for (int n = 4; n <= 20; n++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.product !== 16'd252 || bus.match !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_ignore: done=%b product=%h match=%b, required 1 00fc 1", bus.done, bus.product, bus.match);
    end
    bus.start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_not_queued: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic hold_ok, busy_ok;
    logic seen;
    bus.multiplicand = 8'd50;
    bus.multiplier = 8'd3;
    bus.addend = 8'd2;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.product, bus.match, bus.busy, bus.done} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_mid: product=%h match=%b busy=%b done=%b, required all 0", bus.product, bus.match, bus.busy, bus.done);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= bus.done | bus.busy;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_lost_op: done/busy seen=%b after reset, required 0", seen);
    end
    run_op(8'd21, 8'd10, 8'd3, 8'd213, lat, hold_ok, busy_ok);
    n_checks++;
    if (lat != 9 || bus.product !== 16'd213 || bus.match !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset_op: latency=%0d product=%h match=%b, required 9 00d5 1", lat, bus.product, bus.match);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic hold_ok, busy_ok;
    run_op(8'd3, 8'd4, 8'd1, 8'd13, lat, hold_ok, busy_ok);
    n_checks++;
    if (lat != 9 || bus.product !== 16'd13 || bus.match !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: latency=%0d product=%h match=%b, required 9 000d 1", lat, bus.product, bus.match);
    end
    run_op(8'd200, 8'd2, 8'd0, 8'd0, lat, hold_ok, busy_ok);
    n_checks++;
    if (lat != 9 || !busy_ok || bus.product !== 16'd400 || bus.match !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: latency=%0d busy_ok=%b product=%h match=%b, required 9 1 0190 0", lat, busy_ok, bus.product, bus.match);
    end
    n_checks++;
    if (hold_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_hold: product changed while busy (hold_ok=%b), required 1", hold_ok);
    end
  endtask

  task automatic test_random();
    int a, b, ad, ex, d, lat;
    logic hold_ok, busy_ok;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        d = $urandom_range(255);
        b = $urandom_range(255, 1);
        a = d / b;
        ad = d % b;
        ex = ($urandom_range(3) == 0) ? (d ^ 1) : d;
      end else begin
        a = $urandom_range(255);
        b = $urandom_range(255);
        ad = $urandom_range(255);
        ex = $urandom_range(255);
      end
      run_op(8'(a), 8'(b), 8'(ad), 8'(ex), lat, hold_ok, busy_ok);
      n_checks++;
      if (lat != 9 || !busy_ok || !hold_ok || bus.product !== model_product(a, b, ad) || bus.match !== model_match(a, b, ad, ex)) begin
        n_fail++;
        $display("FAIL rand%0d a=%0d b=%0d ad=%0d ex=%0d: lat=%0d busy_ok=%b hold_ok=%b product=%0d match=%b, required 9 1 1 %0d %b",
                 i, a, b, ad, ex, lat, busy_ok, hold_ok, bus.product, bus.match, model_product(a, b, ad), model_match(a, b, ad, ex));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_add_checker_8bit.md
# mul_add_checker_8bit

- Multi-cycle unsigned shift-add multiply-accumulate unit: computes `product = multiplicand * multiplier + addend` (8-bit operands, 16-bit result).
- It is the inverse datapath of the 8-bit divider. Feeding it quotient, divisor and remainder reconstructs the dividend.
- It also compares the result against an expected dividend and checks remainder < divisor.
- It sits beside the divider in the ALU and serves as both the MUL/MAC operation and a self-check for division results.

## Interface
- No parameters; widths fixed at 8-bit operands / 16-bit product.
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-high; clears all state and outputs.
- `start` input 1: request; sampled only in IDLE.
- `multiplicand` input 8: unsigned operand A (divider quotient in check use).
- `multiplier` input 8: unsigned operand B (divider divisor).
- `addend` input 8: unsigned accumulate term (divider remainder).
- `expected` input 8: unsigned value the result is compared against (divider dividend).
- `product` output 16: registered `A*B + addend`; held until next completion.
- `match` output 1: registered; 1 iff `product == {8'h00, expected}` and `addend < multiplier`.
- `busy` output 1: combinational, `state != IDLE`.
- `done` output 1: registered one-cycle pulse on completion.

## Operation
- States: IDLE, MULTIPLYING, FINISHED.
- IDLE:
  - `start`=1 at edge: latch `multiplicand` into `a_reg`, `multiplier` into `b_reg`, `expected` into `exp_reg`.
  - Load `acc[16:0] = {1'b0, addend, multiplier}`, `count = 8`, `rem_ok = (addend < multiplier)`.
  - Go to MULTIPLYING.
  - Operands are sampled only at this edge; later input changes are ignored.
- MULTIPLYING, each edge:
  - `sum[8:0] = acc[15:8] + (acc[0] ? a_reg : 0)`.
  - `acc <= {1'b0, sum, acc[7:1]}`, i.e. the 9-bit sum is shifted right with the low half.
  - `count <= count - 1`.
  - When `count == 1` at the edge, go to FINISHED.
- FINISHED, one edge:
  - `product <= acc[15:0]`.
  - `match <= (acc[15:0] == {8'h00, exp_reg}) & rem_ok`.
  - `done <= 1`.
  - Go to IDLE.
- `done` is cleared on every other edge.
- Width rule: the maximum result is 255*255+255 = 65280 < 2^16, so there is no overflow. The carry bit `acc[16]` is always 0 after each shift.
- `multiplier == 0` is legal: `product = addend`, and `match = 0` because `addend < 0` is false. There is no error flag.
- `start` while busy (MULTIPLYING or FINISHED) is ignored. It is not queued.
- Reset mid-operation:
  - State returns to IDLE; all registers and outputs go to 0.
  - No `done` pulse; the operation in flight is lost.

## Timing
- Reset values: `product` = 16'h0000, `match` = 0, `done` = 0, `busy` = 0, internal registers 0, state IDLE.
- Edge E0: `start` sampled high in IDLE. `busy` rises after E0.
- E1..E8: eight multiply steps. Transition to FINISHED at E8.
- E9: `product`, `match` updated and `done` = 1. State returns to IDLE, so `busy` falls after E9.
- `done` is high for the cycle between E9 and E10 only.
- Latency from `start` sample to result valid is 9 clock edges.
- Earliest back-to-back `start` sample is E10, giving a throughput of one operation per 10 cycles.
- `product` and `match` are stable from E9 until the next operation's completion edge. They do not change while busy.

## Test plan
- Reset, no start: `product` = 0, `match` = 0, `busy` = 0, `done` = 0.
- Check a correct division:
  - Stimulus: A=13, B=19, addend=5, expected=252, start at E0.
  - Response: `busy` high E0–E9, `done` pulse after E9, `product` = 252 (16'h00FC), `match` = 1.
- Detect a wrong division result:
  - Case 1: A=13, B=19, addend=5, expected=251 gives `product` = 252, `match` = 0.
  - Case 2: A=12, B=19, addend=24, expected=252 gives `product` = 252, `match` = 0 (remainder ≥ divisor).
- Extremes:
  - A=255, B=255, addend=255 gives `product` = 16'hFF00, `match` = 0 (expected cannot equal it).
  - A=0, B=0, addend=7, expected=7 gives `product` = 7, `match` = 0.
- Busy and reset handling:
  - `start` with new operands asserted at E4 is ignored, and the result matches the original operands.
  - Reset asserted at E5: outputs return to 0 immediately and there is no `done`.
  - A new start afterwards completes normally 9 edges later.
- Back-to-back: start at E0 with A=3, B=4, addend=1 gives 13. Start at E10 with A=200, B=2, addend=0 gives 400. Both `done` pulses are seen, and `product` holds 13 until the second result.
